// File: rtl/phshift_mc_pkg.sv
// Shared constants for the multi-channel phase/gain shifter: Q-format unity,
// saturation bounds, rounding bias and the coefficient-select/swap encodings.
package phshift_mc_pkg;

  typedef enum logic {COEF_G1 = 1'b0, COEF_G2 = 1'b1} coef_sel_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} swap_state_e;

  // Largest positive gain, i.e. just under +1.0 in Q1.(GW-1)
  function automatic int q_unity(input int gw);
    return (1 << (gw - 1)) - 1;
  endfunction

  function automatic int sat_hi(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int dw);
    return -(1 << (dw - 1));
  endfunction

  function automatic int round_bias(input int gw);
    return 1 << (gw - 2);
  endfunction

endpackage

// File: rtl/phshift_mc_hist.sv
// Per-channel STEP-deep delay line; rd_data is the addressed channel's sample
// from STEP writes ago, read before the same-cycle write lands.
module phshift_mc_hist #(
  parameter int DW   = 16,
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int STEP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CHW-1:0]       ch,
  input  logic signed [DW-1:0] wr_data,
  output logic signed [DW-1:0] rd_data
);

  logic signed [DW-1:0] hist_q [NCH][STEP];
  logic signed [DW-1:0] hist_d [NCH][STEP];

  always_comb begin
    hist_d  = hist_q;
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CHW'(c) == ch) begin
        rd_data = hist_q[c][STEP-1];
        if (wr_en) begin
          for (int k = STEP - 1; k > 0; k--) hist_d[c][k] = hist_q[c][k-1];
          hist_d[c][0] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= '{default: '0};
    else     hist_q <= hist_d;
  end

endmodule

// File: rtl/phshift_mc.sv
// Multi-channel phase/gain shifter y = g1*x[n] + g2*x[n-STEP] with double-buffered
// coefficients swapped at frame sync. Define PHSHIFT_MC_ROUND_EN for round-half-up.
module phshift_mc
  import phshift_mc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int GW   = 16,
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int STEP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] d_in,
  input  logic                 d_in_valid,
  input  logic                 d_in_sync,
  output logic signed [DW-1:0] d_out,
  output logic                 d_out_valid,
  output logic                 d_out_sync,
  output logic [CHW-1:0]       d_out_ch,
  input  logic [CHW:0]         coef_addr,
  input  logic signed [GW-1:0] coef_data,
  input  logic                 coef_we,
  input  logic                 coef_swap,
  output logic                 swap_pending,
  output logic                 sat_flag,
  input  logic                 sat_clr
);

  localparam int PW = DW + GW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(DW));
  localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(DW));

  swap_state_e state_q, state_d;
  logic signed [GW-1:0] shadow_q [2][NCH];
  logic signed [GW-1:0] shadow_d [2][NCH];
  logic signed [GW-1:0] active_q [2][NCH];
  logic signed [GW-1:0] active_d [2][NCH];
  logic [CHW-1:0] cnt_q, cnt_d, ch_cur;
  logic in_sync, apply;

  logic                 s1_valid_q, s1_valid_d, s1_sync_q, s1_sync_d;
  logic [CHW-1:0]       s1_ch_q, s1_ch_d;
  logic signed [DW-1:0] s1_x_q, s1_x_d, s1_xo_q, s1_xo_d, x_old;
  logic signed [GW-1:0] s1_g1_q, s1_g1_d, s1_g2_q, s1_g2_d;

  logic                 s2_valid_q, s2_valid_d, s2_sync_q, s2_sync_d;
  logic [CHW-1:0]       s2_ch_q, s2_ch_d;
  logic signed [PW-1:0] p1_q, p1_d, p2_q, p2_d;

  logic signed [SW-1:0] sum, shifted;
  logic                 clip_hi, clip_lo;
  logic signed [DW-1:0] d_out_q, d_out_d;
  logic                 d_out_valid_q, d_out_valid_d, d_out_sync_q, d_out_sync_d;
  logic [CHW-1:0]       d_out_ch_q, d_out_ch_d;
  logic                 sat_q, sat_d;

  phshift_mc_hist #(.DW(DW), .NCH(NCH), .CHW(CHW), .STEP(STEP)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (d_in_valid),
    .ch      (ch_cur),
    .wr_data (d_in),
    .rd_data (x_old)
  );

  // Channel tracking, shadow writes and the atomic shadow->active copy
  always_comb begin
    in_sync = d_in_valid & d_in_sync;
    ch_cur  = in_sync ? '0 : cnt_q;
    cnt_d   = cnt_q;
    if (d_in_valid) cnt_d = (ch_cur == CHW'(NCH - 1)) ? '0 : ch_cur + CHW'(1);

    shadow_d = shadow_q;
    for (int c = 0; c < NCH; c++) begin
      if (coef_we && CHW'(c) == coef_addr[CHW-1:0]) begin
        if (coef_sel_e'(coef_addr[CHW]) == COEF_G1) shadow_d[0][c] = coef_data;
        else                                          shadow_d[1][c] = coef_data;
      end
    end

    apply    = in_sync & ((state_q == ST_PEND) | coef_swap);
    active_d = apply ? shadow_d : active_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (coef_swap && !in_sync) state_d = ST_PEND;
      ST_PEND: if (in_sync) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // S1: capture sample, history tap and post-swap gains; S2: products
  always_comb begin
    s1_valid_d = d_in_valid;
    s1_sync_d  = in_sync;
    s1_ch_d    = ch_cur;
    s1_x_d     = d_in;
    s1_xo_d    = x_old;
    s1_g1_d    = '0;
    s1_g2_d    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CHW'(c) == ch_cur) begin
        s1_g1_d = active_d[0][c];
        s1_g2_d = active_d[1][c];
      end
    end

    s2_valid_d = s1_valid_q;
    s2_sync_d  = s1_sync_q;
    s2_ch_d    = s1_ch_q;
    p1_d       = PW'(s1_g1_q) * PW'(s1_x_q);
    p2_d       = PW'(s1_g2_q) * PW'(s1_xo_q);
  end

  // S3: sum, scale back to DW and clip
  always_comb begin
    sum = $signed({p1_q[PW-1], p1_q}) + $signed({p2_q[PW-1], p2_q});
`ifdef PHSHIFT_MC_ROUND_EN
    sum = sum + SW'(round_bias(GW));
`endif
    shifted = sum >>> (GW - 1);
    clip_hi = shifted > SAT_HI;
    clip_lo = shifted < SAT_LO;

    d_out_valid_d = s2_valid_q;
    d_out_sync_d  = s2_valid_q & s2_sync_q;
    d_out_ch_d    = s2_valid_q ? s2_ch_q : '0;
    d_out_d       = '0;
    if (s2_valid_q) begin
      if (clip_hi)      d_out_d = DW'(SAT_HI);
      else if (clip_lo) d_out_d = DW'(SAT_LO);
      else              d_out_d = shifted[DW-1:0];
    end
    sat_d = (sat_q & ~sat_clr) | (s2_valid_q & (clip_hi | clip_lo));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      cnt_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_sync_q     <= 1'b0;
      s1_ch_q       <= '0;
      s1_x_q        <= '0;
      s1_xo_q       <= '0;
      s1_g1_q       <= '0;
      s1_g2_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_sync_q     <= 1'b0;
      s2_ch_q       <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      d_out_q       <= '0;
      d_out_valid_q <= 1'b0;
      d_out_sync_q  <= 1'b0;
      d_out_ch_q    <= '0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      cnt_q         <= cnt_d;
      s1_valid_q    <= s1_valid_d;
      s1_sync_q     <= s1_sync_d;
      s1_ch_q       <= s1_ch_d;
      s1_x_q        <= s1_x_d;
      s1_xo_q       <= s1_xo_d;
      s1_g1_q       <= s1_g1_d;
      s1_g2_q       <= s1_g2_d;
      s2_valid_q    <= s2_valid_d;
      s2_sync_q     <= s2_sync_d;
      s2_ch_q       <= s2_ch_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      d_out_q       <= d_out_d;
      d_out_valid_q <= d_out_valid_d;
      d_out_sync_q  <= d_out_sync_d;
      d_out_ch_q    <= d_out_ch_d;
      sat_q         <= sat_d;
    end
  end

  assign d_out        = d_out_q;
  assign d_out_valid  = d_out_valid_q;
  assign d_out_sync   = d_out_sync_q;
  assign d_out_ch     = d_out_ch_q;
  assign swap_pending = (state_q == ST_PEND);
  assign sat_flag     = sat_q;

endmodule
